// File: rtl/cd101_pkg.sv
// Shared types and constants for the synth voice envelope path.
package cd101_pkg;

  localparam int ENV_W = 8;
  localparam int ACC_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Rate values act on acc[11:4], so a full-scale step is 1/16 of range.
  function automatic logic [ACC_W-1:0] step_ext(input logic [ENV_W-1:0] x);
    return {4'b0, x, 4'b0};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for single-bit level signals crossing into clk.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator: prescaled tick, gate edge detect, 5-state FSM
// driving a 16-bit accumulator whose top byte is the output amplitude.
module adsr_env
  import cd101_pkg::*;
#(
  parameter int PRESCALE_W = 9
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             trig,
  input  logic             progn,
  input  logic [ENV_W-1:0] adsr_ai,
  input  logic [ENV_W-1:0] adsr_di,
  input  logic [ENV_W-1:0] adsr_s,
  input  logic [ENV_W-1:0] adsr_ri,
  output logic [ENV_W-1:0] env,
  output logic             active,
  output logic [2:0]       state
);

  logic                  w_trig_s;
  logic                  w_progn_s;
  logic                  r_trig_d;
  logic [PRESCALE_W-1:0] r_pre;
  logic [ACC_W-1:0]      r_acc;
  state_t                r_state;
  logic                  r_active;

  logic                  w_tick;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_mute;
  state_t                w_nstate;
  logic [ACC_W-1:0]      w_nacc;

  logic [ACC_W-1:0]      w_ai_ext;
  logic [ACC_W-1:0]      w_di_ext;
  logic [ACC_W-1:0]      w_ri_ext;
  logic [ACC_W-1:0]      w_s16;
  logic [ACC_W:0]        w_sum;
  logic [ACC_W:0]        w_dif;

  sync2 u_sync_trig (
    .i_clk   (clk),
    .i_rst_n (arstn),
    .i_d     (trig),
    .o_q     (w_trig_s)
  );

  sync2 u_sync_progn (
    .i_clk   (clk),
    .i_rst_n (arstn),
    .i_d     (progn),
    .o_q     (w_progn_s)
  );

  assign w_mute   = ~w_progn_s;
  assign w_tick   = &r_pre;
  assign w_rise   = w_trig_s & ~r_trig_d;
  assign w_fall   = ~w_trig_s & r_trig_d;

  assign w_ai_ext = step_ext(adsr_ai);
  assign w_di_ext = step_ext(adsr_di);
  assign w_ri_ext = step_ext(adsr_ri);
  assign w_s16    = {adsr_s, 8'h00};
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_ai_ext};
  // Borrow in bit 16 means the step overshot zero, i.e. below any target.
  assign w_dif    = {1'b0, r_acc} - {1'b0, w_di_ext};

  // Edge tracking runs through mute so a gate held high across
  // programming does not look like a fresh rising edge afterwards.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_trig_d <= 1'b0;
    else        r_trig_d <= w_trig_s;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)      r_pre <= '0;
    else if (w_mute) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_active <= 1'b0;
    end else if (w_mute) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_acc    <= w_nacc;
      r_active <= (w_nstate != IDLE);
    end
  end

  // Edges pre-empt the tick: state moves, accumulator untouched.
  always_comb begin
    w_nstate = r_state;
    w_nacc   = r_acc;
    if (w_rise) begin
      w_nstate = ATTACK;
    end else if (w_fall && (r_state == ATTACK || r_state == DECAY ||
                            r_state == SUSTAIN)) begin
      w_nstate = RELEASE;
    end else if (w_tick) begin
      case (r_state)
        ATTACK: begin
          if (adsr_ai == '0 || w_sum >= {1'b0, 16'hFFFF}) begin
            w_nacc   = 16'hFFFF;
            w_nstate = DECAY;
          end else begin
            w_nacc   = w_sum[ACC_W-1:0];
          end
        end
        DECAY: begin
          if (adsr_di == '0 || w_dif[ACC_W] || w_dif[ACC_W-1:0] <= w_s16) begin
            w_nacc   = w_s16;
            w_nstate = SUSTAIN;
          end else begin
            w_nacc   = w_dif[ACC_W-1:0];
          end
        end
        SUSTAIN: w_nacc = r_acc;
        RELEASE: begin
          if (adsr_ri == '0 || r_acc <= w_ri_ext) begin
            w_nacc   = '0;
            w_nstate = IDLE;
          end else begin
            w_nacc   = r_acc - w_ri_ext;
          end
        end
        IDLE:    w_nacc = '0;
        default: begin
          w_nacc   = '0;
          w_nstate = IDLE;
        end
      endcase
    end
  end

  assign env    = r_acc[ACC_W-1:ACC_W-ENV_W];
  assign active = r_active;
  assign state  = r_state;

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env with a 4-cycle tick; expected values hand-derived.
module tb_adsr_env;

  logic       clk = 1'b0;
  logic       arstn;
  logic       trig;
  logic       progn;
  logic [7:0] ai, di, s, ri;
  logic [7:0] env;
  logic       active;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_ATT = 3'd1, S_DEC = 3'd2,
                         S_SUS = 3'd3, S_REL = 3'd4;

  adsr_env #(.PRESCALE_W(2)) dut (
    .clk     (clk),
    .arstn   (arstn),
    .trig    (trig),
    .progn   (progn),
    .adsr_ai (ai),
    .adsr_di (di),
    .adsr_s  (s),
    .adsr_ri (ri),
    .env     (env),
    .active  (active),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance until env moves; a missing tick counts as a failed comparison.
  task automatic wait_chg(input string tag);
    logic [7:0] p;
    int i;
    p = env;
    for (i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (env !== p) break;
    end
    chk({tag, "_tmo"}, {15'b0, i < 8}, 16'd1);
  endtask

  task automatic edges3;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    arstn = 1'b0; trig = 1'b0; progn = 1'b1;
    ai = 8'h80; di = 8'h40; s = 8'h80; ri = 8'h20;
    #1;
    chk("rst_env", {8'h0, env}, 16'h0);
    chk("rst_state", {13'h0, state}, {13'h0, S_IDLE});
    chk("rst_active", {15'h0, active}, 16'h0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_env", {8'h0, env}, 16'h0);

    // Full cycle
    @(negedge clk); trig = 1'b1;
    edges3();
    chk("att_lat_state", {13'h0, state}, {13'h0, S_ATT});
    chk("att_lat_active", {15'h0, active}, 16'h1);
    chk("att_lat_env", {8'h0, env}, 16'h0);
    for (int k = 1; k <= 32; k++) begin
      wait_chg("att");
      chk("att_env", {8'h0, env}, (k < 32) ? 16'(8 * k) : 16'h00FF);
    end
    chk("att_to_dec", {13'h0, state}, {13'h0, S_DEC});
    for (int k = 1; k <= 32; k++) begin
      wait_chg("dec");
      chk("dec_env", {8'h0, env}, (k < 32) ? 16'(255 - 4 * k) : 16'h0080);
    end
    chk("dec_to_sus", {13'h0, state}, {13'h0, S_SUS});
    repeat (12) @(posedge clk);
    #1;
    chk("sus_hold", {8'h0, env}, 16'h0080);
    @(negedge clk); trig = 1'b0;
    edges3();
    chk("rel_state", {13'h0, state}, {13'h0, S_REL});
    chk("rel_env0", {8'h0, env}, 16'h0080);
    for (int k = 1; k <= 64; k++) begin
      wait_chg("rel");
      chk("rel_env", {8'h0, env}, 16'(128 - 2 * k));
    end
    chk("rel_idle", {13'h0, state}, {13'h0, S_IDLE});
    chk("rel_active", {15'h0, active}, 16'h0);

    // Zero rates
    ai = 8'h00; di = 8'h00; ri = 8'h00; s = 8'h40;
    @(negedge clk); trig = 1'b1;
    edges3();
    chk("z_att", {13'h0, state}, {13'h0, S_ATT});
    wait_chg("z1");
    chk("z_env_ff", {8'h0, env}, 16'h00FF);
    chk("z_dec", {13'h0, state}, {13'h0, S_DEC});
    wait_chg("z2");
    chk("z_env_s", {8'h0, env}, 16'h0040);
    chk("z_sus", {13'h0, state}, {13'h0, S_SUS});
    @(negedge clk); trig = 1'b0;
    edges3();
    chk("z_rel", {13'h0, state}, {13'h0, S_REL});
    wait_chg("z3");
    chk("z_env_0", {8'h0, env}, 16'h0);
    chk("z_idle", {13'h0, state}, {13'h0, S_IDLE});

    // Retrigger in RELEASE at 0x60
    s = 8'h80; ri = 8'h20;
    @(negedge clk); trig = 1'b1;
    edges3();
    wait_chg("rt1");
    wait_chg("rt2");
    chk("rt_sus", {8'h0, env}, 16'h0080);
    @(negedge clk); trig = 1'b0;
    edges3();
    for (int k = 1; k <= 16; k++) begin
      wait_chg("rt_rel");
      chk("rt_rel_env", {8'h0, env}, 16'(128 - 2 * k));
    end
    @(negedge clk); trig = 1'b1; ai = 8'h10;
    edges3();
    chk("rt_att", {13'h0, state}, {13'h0, S_ATT});
    chk("rt_nodip", {8'h0, env}, 16'h0060);
    wait_chg("rt3");
    chk("rt_resume", {8'h0, env}, 16'h0061);
    ai = 8'h00;
    wait_chg("rt4");
    wait_chg("rt5");
    chk("rt_sus2", {13'h0, state}, {13'h0, S_SUS});

    // Mute with trig held high
    @(negedge clk); progn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mute_pre", {8'h0, env}, 16'h0080);
    @(posedge clk); #1;
    chk("mute_env", {8'h0, env}, 16'h0);
    chk("mute_state", {13'h0, state}, {13'h0, S_IDLE});
    chk("mute_active", {15'h0, active}, 16'h0);
    @(negedge clk); progn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("unmute_idle", {13'h0, state}, {13'h0, S_IDLE});
    chk("unmute_env", {8'h0, env}, 16'h0);
    @(negedge clk); trig = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("fall_in_idle", {13'h0, state}, {13'h0, S_IDLE});

    // Edge/tick collision in DECAY
    ai = 8'h00; di = 8'h10; s = 8'h00; ri = 8'h10;
    @(negedge clk); trig = 1'b1;
    edges3();
    chk("col_att", {13'h0, state}, {13'h0, S_ATT});
    begin
      int i;
      for (i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (state === S_DEC) break;
      end
      chk("col_dec_tmo", {15'b0, i < 8}, 16'd1);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("col_dec_env", {8'h0, env}, 16'h00FE);
    @(posedge clk);
    @(negedge clk); trig = 1'b0;
    edges3();
    chk("col_rel", {13'h0, state}, {13'h0, S_REL});
    chk("col_acc_kept", {8'h0, env}, 16'h00FE);
    repeat (4) @(posedge clk);
    #1;
    chk("col_rel_step", {8'h0, env}, 16'h00FD);

    // Asynchronous reset mid-attack
    @(negedge clk); trig = 1'b1; ai = 8'h10;
    edges3();
    chk("ra_att", {13'h0, state}, {13'h0, S_ATT});
    @(negedge clk); arstn = 1'b0; trig = 1'b0;
    #1;
    chk("ra_env", {8'h0, env}, 16'h0);
    chk("ra_state", {13'h0, state}, {13'h0, S_IDLE});
    chk("ra_active", {15'h0, active}, 16'h0);
    @(negedge clk); arstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ra_stay_idle", {13'h0, state}, {13'h0, S_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
